// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: FSM state encoding and default widths for seq_pattern_gen
package seq_gen_pkg;
  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int REP_W = 4;
  localparam int GAP_W = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, FIN} state_e;
endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down-counter with zero flag
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = load_i ? val_i : dec_i ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter with repeat and gap; define SEQ_GEN_LSB_FIRST_EN for LSB-first order
module seq_pattern_gen #(
  parameter int PAT_W = seq_gen_pkg::PAT_W,
  parameter int LEN_W = seq_gen_pkg::LEN_W,
  parameter int REP_W = seq_gen_pkg::REP_W,
  parameter int GAP_W = seq_gen_pkg::GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             busy,
  output logic             done
);
  import seq_gen_pkg::*;
  state_e state_q, state_d;
  logic out_q, out_d;
  logic [PAT_W-1:0] pat_q, sh_q, sh_d, ld_pat, aligned, fst_rest, nxt_rest;
  logic [LEN_W-1:0] len_q, len_c, ld_len;
  logic [GAP_W-1:0] gap_q;
  logic [REP_W-1:0] reps_m1;
  logic fst_bit, nxt_bit, accept;
  logic idx_ld, idx_dec, idx_zero, rep_ld, rep_dec, rep_zero, gap_ld, gap_dec, gap_zero;
  assign accept  = state_q == IDLE && start;
  assign len_c   = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
  assign reps_m1 = (reps == '0) ? '0 : reps - REP_W'(1);
  // Start of a transmission reads the live inputs, later repetitions the shadow copy
  assign ld_pat  = state_q == IDLE ? pattern : pat_q;
  assign ld_len  = state_q == IDLE ? len_c : len_q;
`ifdef SEQ_GEN_LSB_FIRST_EN
  assign aligned  = ld_pat;
  assign fst_bit  = aligned[0];
  assign fst_rest = aligned >> 1;
  assign nxt_bit  = sh_q[0];
  assign nxt_rest = sh_q >> 1;
`else
  assign aligned  = ld_pat << (PAT_W - int'(ld_len));
  assign fst_bit  = aligned[PAT_W-1];
  assign fst_rest = aligned << 1;
  assign nxt_bit  = sh_q[PAT_W-1];
  assign nxt_rest = sh_q << 1;
`endif
  always_comb begin
    state_d = state_q;
    out_d   = 1'b0;
    sh_d    = sh_q;
    idx_ld  = 1'b0;
    idx_dec = 1'b0;
    rep_ld  = 1'b0;
    rep_dec = 1'b0;
    gap_ld  = 1'b0;
    gap_dec = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        rep_ld = 1'b1;
        if (len_c == '0) state_d = FIN;
        else begin
          state_d = SHIFT;
          idx_ld  = 1'b1;
          out_d   = fst_bit;
          sh_d    = fst_rest;
        end
      end
      SHIFT: if (!idx_zero) begin
        idx_dec = 1'b1;
        out_d   = nxt_bit;
        sh_d    = nxt_rest;
      end else if (rep_zero) state_d = FIN;
      else begin
        rep_dec = 1'b1;
        if (gap_q != '0) begin
          state_d = GAP;
          gap_ld  = 1'b1;
        end else begin
          idx_ld = 1'b1;
          out_d  = fst_bit;
          sh_d   = fst_rest;
        end
      end
      GAP: if (gap_zero) begin
        state_d = SHIFT;
        idx_ld  = 1'b1;
        out_d   = fst_bit;
        sh_d    = fst_rest;
      end else gap_dec = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= 1'b0;
      sh_q    <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sh_q    <= sh_d;
      if (accept) begin
        pat_q <= pattern;
        len_q <= len_c;
        gap_q <= gap;
      end
    end
  end
  seq_down_counter #(.W(LEN_W)) u_idx (
    .clk(clk), .rst(rst), .load_i(idx_ld), .dec_i(idx_dec),
    .val_i(ld_len - LEN_W'(1)), .zero_o(idx_zero)
  );
  seq_down_counter #(.W(REP_W)) u_rep (
    .clk(clk), .rst(rst), .load_i(rep_ld), .dec_i(rep_dec),
    .val_i(reps_m1), .zero_o(rep_zero)
  );
  seq_down_counter #(.W(GAP_W)) u_gap (
    .clk(clk), .rst(rst), .load_i(gap_ld), .dec_i(gap_dec),
    .val_i(gap_q - GAP_W'(1)), .zero_o(gap_zero)
  );
  assign out  = out_q;
  assign busy = state_q == SHIFT || state_q == GAP;
  assign done = state_q == FIN;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed and random stimulus against a cycle-index reference model
module tb_seq_pattern_gen;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0, reps = '0, gap = '0;
  logic out, busy, done;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  bit m_act = 1'b0;
  int m_j, m_l, m_r, m_g;
  logic [7:0] m_pat;
  logic [2:0] log_q [0:511];
  logic [9:0] lit2;

  seq_pattern_gen dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .reps(reps), .gap(gap), .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int tot(int l, int r, int g);
    return (l == 0) ? 0 : r * l + (r - 1) * g;
  endfunction

  // expected {out,busy,done} in the j-th cycle after start was accepted
  function automatic logic [2:0] exp_at(int j, logic [7:0] p, int l, int r, int g);
    int t, k;
    t = tot(l, r, g);
    if (j == t + 1) return 3'b001;
    if (j < 1 || j > t) return 3'b000;
    k = (j - 1) % (l + g);
    if (k >= l) return 3'b010;
`ifdef SEQ_GEN_LSB_FIRST_EN
    return {p[k], 2'b10};
`else
    return {p[l-1-k], 2'b10};
`endif
  endfunction

  task automatic check(string n, logic [2:0] got, logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b exp %b", n, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) m_act = 1'b0;
    else if (!m_act && start) begin
      m_act = 1'b1;
      m_j   = 1;
      m_pat = pattern;
      m_l   = (int'(len) > 8) ? 8 : int'(len);
      m_r   = (reps == '0) ? 1 : int'(reps);
      m_g   = int'(gap);
    end else if (m_act) begin
      m_j++;
      if (m_j > tot(m_l, m_r, m_g) + 1) m_act = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (m_act && m_j < 512) log_q[m_j] = {out, busy, done};
      check("stream", {out, busy, done}, m_act ? exp_at(m_j, m_pat, m_l, m_r, m_g) : 3'b000);
    end
  end

  task automatic send(logic [7:0] p, logic [3:0] l, logic [3:0] r, logic [3:0] g);
    @(posedge clk); #1;
    start = 1'b1; pattern = p; len = l; reps = r; gap = g;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_act && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (m_act) begin
      checks++;
      errors++;
      $display("FAIL timeout t=%0t got busy exp idle", $time);
    end
    @(negedge clk);
  endtask

  initial begin
`ifdef SEQ_GEN_LSB_FIRST_EN
    lit2 = 10'b1101001101;
`else
    lit2 = 10'b1011001011;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset", {out, busy, done}, 3'b000);
    send(8'b0000_0111, 4'd3, 4'd1, 4'd0);
    wait_idle();
    for (int j = 1; j <= 3; j++) check("t1_bit", log_q[j], 3'b110);
    check("t1_done", log_q[4], 3'b001);
    send(8'b0000_1011, 4'd4, 4'd2, 4'd2);
    wait_idle();
    for (int j = 1; j <= 10; j++) check("t2_out", {2'b00, log_q[j][2]}, {2'b00, lit2[10-j]});
    check("t2_gap", log_q[5], 3'b010);
    check("t2_done", log_q[11], 3'b001);
    send(8'b0000_0111, 4'd3, 4'd2, 4'd0);
    wait_idle();
    for (int j = 1; j <= 6; j++) check("t3_run", log_q[j], 3'b110);
    check("t3_done", log_q[7], 3'b001);
    send(8'hFF, 4'd0, 4'd3, 4'd2);
    wait_idle();
    check("t4_len0", log_q[1], 3'b001);
    send(8'hA5, 4'd9, 4'd1, 4'd0);
    wait_idle();
    check("t4_clamp_last", log_q[8], 3'b110);
    check("t4_clamp_done", log_q[9], 3'b001);
    @(posedge clk); #1;
    start = 1'b1; pattern = 8'b0000_1101; len = 4'd4; reps = 4'd1; gap = 4'd0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; pattern = 8'hF0; reps = 4'd3;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    check("t5_done", log_q[5], 3'b001);
    @(negedge clk);
    check("t5_single", {out, busy, done}, 3'b000);
    send(8'b1010_1010, 4'd4, 4'd3, 4'd1);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_abort", {out, busy, done}, 3'b000);
    send(8'b0000_1001, 4'd4, 4'd1, 4'd0);
    wait_idle();
    check("t6_first", log_q[1], 3'b110);
    check("t6_mid", log_q[2], 3'b010);
    check("t6_done", log_q[5], 3'b001);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      start   = ($urandom % 4) == 0;
      pattern = 8'($urandom);
      len     = 4'($urandom);
      reps    = 4'($urandom_range(0, 4));
      gap     = 4'($urandom_range(0, 3));
      rst     = ($urandom % 300) == 0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
